// File: rtl/udma_pkg.sv
// Shared definitions for the uDMA RX linear-channel arbiter:
// transfer-size encoding, the buffered beat record and the size-masking helper.
package udma_pkg;

    localparam logic [1:0] UDMA_SIZE_8    = 2'd0;
    localparam logic [1:0] UDMA_SIZE_16   = 2'd1;
    localparam logic [1:0] UDMA_SIZE_32   = 2'd2;
    localparam logic [1:0] UDMA_SIZE_RSVD = 2'd3;

    // Beat fields are sized for the largest legal configuration (32-bit data,
    // 32 channels); narrower instances zero-extend on push and truncate on read.
    localparam int UDMA_MAX_DATA_W = 32;
    localparam int UDMA_MAX_ID_W   = 5;

    typedef struct packed {
        logic [UDMA_MAX_DATA_W-1:0] data;
        logic [1:0]                 size;
        logic [UDMA_MAX_ID_W-1:0]   id;
    } udma_rx_beat_t;

    // Keep only the bytes covered by the transfer size; the reserved code
    // behaves like a full word.
    function automatic logic [UDMA_MAX_DATA_W-1:0] udma_size_mask(
        input logic [UDMA_MAX_DATA_W-1:0] data,
        input logic [1:0]                 size
    );
        logic [UDMA_MAX_DATA_W-1:0] keep;
        case (size)
            UDMA_SIZE_8:  keep = 32'h0000_00FF;
            UDMA_SIZE_16: keep = 32'h0000_FFFF;
            default:      keep = 32'hFFFF_FFFF;
        endcase
        return data & keep;
    endfunction

    // The reserved size code is stored as a 4-byte transfer.
    function automatic logic [1:0] udma_size_norm(input logic [1:0] size);
        return (size == UDMA_SIZE_RSVD) ? UDMA_SIZE_32 : size;
    endfunction

endpackage

// File: rtl/udma_rx_arb_fifo.sv
// Small synchronous FIFO of udma_rx_beat_t with occupancy output.
// Pointers carry one extra MSB so full and empty are distinguishable.
// The head is read combinationally so a beat pushed into an empty FIFO is
// visible on the very next cycle; the depth is small enough for LUT storage.
module udma_rx_arb_fifo
    import udma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  udma_rx_beat_t            push_beat_i,
    input  logic                     pop_i,
    output udma_rx_beat_t            head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    udma_rx_beat_t mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    // Head fields read as zero while empty so stale storage never leaks out.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; overflow and underflow requests are ignored.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers, cleared by reset so all content is discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; no reset needed because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_beat_i;
        end
    end

endmodule

// File: rtl/udma_rx_lin_arbiter.sv
// N-channel round-robin RX arbiter feeding one buffered uDMA stream.
// Optional feature macro: UDMA_RX_ARB_PRIO_EN adds ch_prio_i; eligible
// channels with prio set are served first, still in round-robin order.
// Grant depends only on requests, rr pointer and the FIFO's registered
// pointers, so out_ready_i never reaches ch_ready_o combinationally.
module udma_rx_lin_arbiter
    import udma_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = $clog2(N_CH)
) (
    input  logic                             sys_clk_i,
    input  logic                             HRESETn,
    input  logic [N_CH-1:0]                  ch_en_i,
    input  logic [N_CH-1:0]                  ch_valid_i,
    input  logic [N_CH*DATA_WIDTH-1:0]       ch_data_i,
    input  logic [N_CH*2-1:0]                ch_size_i,
    output logic [N_CH-1:0]                  ch_ready_o,
`ifdef UDMA_RX_ARB_PRIO_EN
    input  logic [N_CH-1:0]                  ch_prio_i,
`endif
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_WIDTH-1:0]            out_data_o,
    output logic [1:0]                       out_size_o,
    output logic [ID_WIDTH-1:0]              out_id_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
    output logic                             size_err_o
);

    logic [DATA_WIDTH-1:0] ch_data [N_CH];
    logic [1:0]            ch_size [N_CH];
    logic [N_CH-1:0]       req_mask;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  grant_vld;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [1:0]            grant_size;
    logic                  size_err_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    udma_rx_beat_t         push_beat;
    udma_rx_beat_t         head_beat;

    // Unpack the flattened per-channel buses.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign ch_data[gi] = ch_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign ch_size[gi] = ch_size_i[gi*2 +: 2];
    end

    // Request set for this cycle, narrowed to high-priority requesters when any exist.
    always_comb begin
        req_mask = ch_valid_i & ch_en_i;
`ifdef UDMA_RX_ARB_PRIO_EN
        if (|(req_mask & ch_prio_i)) begin
            req_mask = req_mask & ch_prio_i;
        end
`endif
    end

    // Round-robin search from rr_ptr, wrapping at N_CH-1; blocked while full or in reset.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!grant_vld && req_mask[idx] && !fifo_full && HRESETn) begin
                grant_vld = 1'b1;
                grant_idx = ID_WIDTH'(idx);
            end
        end
    end

    // One-hot ready for the granted channel only.
    always_comb begin
        ch_ready_o = '0;
        if (grant_vld) begin
            ch_ready_o[grant_idx] = 1'b1;
        end
    end

    // Next rr pointer: one past the granted channel, otherwise hold.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == ID_WIDTH'(N_CH-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Build the beat written into the FIFO from the granted channel.
    always_comb begin
        grant_size     = ch_size[grant_idx];
        push_beat.data = udma_size_mask(UDMA_MAX_DATA_W'(ch_data[grant_idx]), grant_size);
        push_beat.size = udma_size_norm(grant_size);
        push_beat.id   = UDMA_MAX_ID_W'(grant_idx);
    end

    // Pointer and reserved-size error pulse registers.
    always_ff @(posedge sys_clk_i or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_ptr_q   <= '0;
            size_err_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            size_err_q <= grant_vld && (grant_size == UDMA_SIZE_RSVD);
        end
    end

    udma_rx_arb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (sys_clk_i),
        .rst_ni      (HRESETn),
        .push_i      (grant_vld),
        .push_beat_i (push_beat),
        .pop_i       (out_valid_o && out_ready_i),
        .head_o      (head_beat),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .level_o     (fifo_level_o)
    );

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = DATA_WIDTH'(head_beat.data);
    assign out_size_o  = head_beat.size;
    assign out_id_o    = ID_WIDTH'(head_beat.id);
    assign size_err_o  = size_err_q;

endmodule

// File: tb/tb_udma_rx_lin_arbiter.sv
// Directed bench for udma_rx_lin_arbiter with a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_udma_rx_lin_arbiter;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  ch_en;
    logic [N-1:0]  ch_valid;
    logic [N*DW-1:0] ch_data;
    logic [N*2-1:0]  ch_size;
    logic [N-1:0]  ch_ready;
    logic [N-1:0]  ch_prio;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_size;
    logic [2:0]    out_id;
    logic [2:0]    level;
    logic          size_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    udma_rx_lin_arbiter #(
        .N_CH       (N),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk_i    (clk),
        .HRESETn      (rst_n),
        .ch_en_i      (ch_en),
        .ch_valid_i   (ch_valid),
        .ch_data_i    (ch_data),
        .ch_size_i    (ch_size),
        .ch_ready_o   (ch_ready),
`ifdef UDMA_RX_ARB_PRIO_EN
        .ch_prio_i    (ch_prio),
`endif
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_size_o   (out_size),
        .out_id_o     (out_id),
        .fifo_level_o (level),
        .size_err_o   (size_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] d, input logic [1:0] s);
        ch_data[c*DW +: DW] = d;
        ch_size[c*2 +: 2]   = s;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] q_data[$];
    logic [1:0]  q_size[$];
    int          q_id[$];
    int          m_rr  = 0;
    bit          m_err = 1'b0;
    int          dut_grants[$];

    function automatic int model_grant();
        logic [N-1:0] elig;
        if (rst_n !== 1'b1 || q_id.size() >= DEPTH) return -1;
        elig = ch_valid & ch_en;
`ifdef UDMA_RX_ARB_PRIO_EN
        if ((elig & ch_prio) != 0) elig = elig & ch_prio;
`endif
        for (int k = 0; k < N; k++) begin
            if (elig[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge rst_n) begin
        q_data.delete();
        q_size.delete();
        q_id.delete();
        m_rr  = 0;
        m_err = 1'b0;
    end

    // Advance the model on each active edge using the inputs held across it.
    always @(posedge clk) begin : model_p
        int g;
        logic [31:0] d;
        logic [1:0]  s;
        if (rst_n === 1'b1) begin
            g = model_grant();
            if (q_id.size() > 0 && out_ready) begin
                $display("beat out: id=%0d size=%0d data=%08h level=%0d",
                         q_id[0], q_size[0], q_data[0], q_id.size());
                void'(q_data.pop_front());
                void'(q_size.pop_front());
                void'(q_id.pop_front());
            end
            m_err = 1'b0;
            if (g >= 0) begin
                d = ch_data[g*DW +: DW];
                s = ch_size[g*2 +: 2];
                m_err = (s == 2'd3);
                q_data.push_back(s == 2'd0 ? (d & 32'hFF) : s == 2'd1 ? (d & 32'hFFFF) : d);
                q_size.push_back(s == 2'd3 ? 2'd2 : s);
                q_id.push_back(g);
                m_rr = (g + 1) % N;
            end
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin : cmp_p
        int g;
        logic [N-1:0] er;
        g  = model_grant();
        er = (g >= 0) ? N'(1 << g) : '0;
        chk("cmp_ready", ch_ready, er);
        chk("cmp_valid", out_valid, q_id.size() > 0);
        chk("cmp_level", level, q_id.size());
        chk("cmp_size_err", size_err, m_err);
        if (q_id.size() > 0) begin
            chk("cmp_data", out_data, q_data[0]);
            chk("cmp_size", out_size, q_size[0]);
            chk("cmp_id", out_id, q_id[0]);
        end
        if (rst_n === 1'b1) begin
            for (int i = 0; i < N; i++) begin
                if (ch_ready[i]) dut_grants.push_back(i);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] mask_exp [3];
    logic [1:0]  mask_sz  [3];
    int cnt [N];
    int c2, c5;

    initial begin
        mask_exp = '{32'h0000_0078, 32'h0000_5678, 32'h1234_5678};
        mask_sz  = '{2'd0, 2'd1, 2'd3};
        rst_n = 1'b1;
        ch_en = '1; ch_valid = '0; ch_data = '0; ch_size = '0;
        ch_prio = '0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) step();

        // Reset / idle values
        @(negedge clk);
        chk("rst_ready", ch_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_size", out_size, 0);
        chk("rst_id", out_id, 0);
        chk("rst_level", level, 0);
        chk("rst_size_err", size_err, 0);
        step();
        rst_n = 1'b1;

        // Single beat on ch 3, visible one cycle after acceptance
        step();
        set_ch(3, 32'hDEADBEEF, 2'd2);
        ch_valid = 8'h08;
        @(negedge clk);
        chk("ch3_ready", ch_ready, 8'h08);
        chk("ch3_not_yet_valid", out_valid, 0);
        step();
        ch_valid = '0;
        @(negedge clk);
        chk("ch3_valid", out_valid, 1);
        chk("ch3_id", out_id, 3);
        chk("ch3_data", out_data, 32'hDEADBEEF);
        step();
        out_ready = 1'b1;
        repeat (2) step();

        // Size masking on ch 1
        for (int i = 0; i < 3; i++) begin
            set_ch(1, 32'h12345678, mask_sz[i]);
            ch_valid = 8'h02;
            step();
            ch_valid = '0;
            @(negedge clk);
            chk("mask_data", out_data, mask_exp[i]);
            chk("mask_size", out_size, (i == 2) ? 2'd2 : mask_sz[i]);
            chk("mask_err", size_err, i == 2);
            step();
            @(negedge clk);
            chk("mask_err_clear", size_err, 0);
            step();
        end

        // Disabled channel 2 never granted
        ch_en = 8'hFB;
        ch_valid = 8'h24;
        dut_grants.delete();
        repeat (10) step();
        ch_valid = '0;
        c2 = 0; c5 = 0;
        foreach (dut_grants[i]) begin
            if (dut_grants[i] == 2) c2++;
            if (dut_grants[i] == 5) c5++;
        end
        chk("dis_ch2_grants", c2, 0);
        chk("dis_ch5_grants", c5, 10);
        ch_en = '1;
        repeat (2) step();

        // Backpressure: fill to 4, then drain and resume
        out_ready = 1'b0;
        ch_valid = 8'hFF;
        repeat (4) step();
        @(negedge clk);
        chk("full_level", level, 4);
        chk("full_ready", ch_ready, 0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_cycle_ready", ch_ready, 0);
        chk("full_pop_cycle_valid", out_valid, 1);
        step();
        @(negedge clk);
        chk("resume_ready", ch_ready != 0, 1);
        ch_valid = '0;
        repeat (6) step();

        // Async reset with 3 entries held
        out_ready = 1'b0;
        set_ch(0, 32'hA5A5_0000, 2'd2);
        ch_valid = 8'h01;
        repeat (3) step();
        ch_valid = '0;
        #1;
        chk("hold3_level", level, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_level", level, 0);
        chk("async_rst_valid", out_valid, 0);
        repeat (2) step();
        rst_n = 1'b1;

        // Fairness: all channels, sink always ready, 64 cycles
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, 32'h1000_0000 + c, 2'd2);
        ch_valid = 8'hFF;
        dut_grants.delete();
        repeat (64) step();
        ch_valid = '0;
        chk("rr_total", dut_grants.size(), 64);
        for (int i = 0; i < 9; i++) begin
            chk("rr_order", (i < dut_grants.size()) ? dut_grants[i] : -1, i % 8);
        end
        for (int c = 0; c < N; c++) cnt[c] = 0;
        foreach (dut_grants[i]) cnt[dut_grants[i]]++;
        for (int c = 0; c < N; c++) chk("rr_share", cnt[c], 8);
        repeat (3) step();

`ifdef UDMA_RX_ARB_PRIO_EN
        // Priority: ch 6 served exclusively, then round-robin wraps to 0
        ch_prio = 8'h40;
        ch_valid = 8'h51;
        dut_grants.delete();
        repeat (5) step();
        ch_valid = 8'h11;
        step();
        ch_valid = '0;
        chk("prio_total", dut_grants.size(), 6);
        for (int i = 0; i < 5; i++) begin
            chk("prio_only6", (i < dut_grants.size()) ? dut_grants[i] : -1, 6);
        end
        chk("prio_wrap_to0", (dut_grants.size() > 5) ? dut_grants[5] : -1, 0);
        ch_prio = '0;
        repeat (3) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
